// File: rtl/alu_result_stage.sv
// alu_result_stage: registered result stage behind the LEGv8 ALU.
// Holds the architectural NZCV flags, evaluates B.cond against them, and
// buffers {F, rd, take_branch} in a two-entry FIFO with valid/ready on both sides.
// Optional feature macro: TAKEN_COUNT_EN adds a 32-bit count of popped taken branches.
module alu_result_stage #(
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_F,
    input  logic [3:0]        in_status,
    input  logic              in_set_flags,
    input  logic              in_cond_br,
    input  logic [3:0]        in_cond,
    input  logic [4:0]        in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_F,
    output logic [4:0]        out_rd,
    output logic              out_take_branch,
`ifdef TAKEN_COUNT_EN
    output logic [31:0]       taken_count,
`endif
    output logic [3:0]        flags
);

    // Entry 0 is always the head; entry 1 is the tail when two are held.
    logic [1:0]        r_count;
    logic [DATA_W-1:0] r_F   [2];
    logic [4:0]        r_rd  [2];
    logic              r_tb  [2];
    logic [3:0]        r_flags;

    logic w_push;
    logic w_pop;
    logic w_cond_true;
    logic w_take;
    logic w_v, w_c, w_n, w_z;

    assign in_ready        = (r_count < 2'd2) && !reset;
    assign out_valid       = (r_count != 2'd0);
    assign w_push          = in_valid && in_ready;
    assign w_pop           = out_valid && out_ready;
    assign out_F           = r_F[0];
    assign out_rd          = r_rd[0];
    assign out_take_branch = r_tb[0];
    assign flags           = r_flags;

    assign {w_v, w_c, w_n, w_z} = r_flags;

    // Condition evaluation against the flags registered before this beat.
    always_comb begin
        w_cond_true = 1'b0;
        case (in_cond)
            4'h0:    w_cond_true = w_z;
            4'h1:    w_cond_true = !w_z;
            4'h2:    w_cond_true = w_c;
            4'h3:    w_cond_true = !w_c;
            4'h4:    w_cond_true = w_n;
            4'h5:    w_cond_true = !w_n;
            4'h6:    w_cond_true = w_v;
            4'h7:    w_cond_true = !w_v;
            4'h8:    w_cond_true = w_c && !w_z;
            4'h9:    w_cond_true = !w_c || w_z;
            4'hA:    w_cond_true = (w_n == w_v);
            4'hB:    w_cond_true = (w_n != w_v);
            4'hC:    w_cond_true = !w_z && (w_n == w_v);
            4'hD:    w_cond_true = w_z || (w_n != w_v);
            default: w_cond_true = 1'b1;
        endcase
    end

    assign w_take = in_cond_br && w_cond_true;

    // FIFO storage and occupancy; a popped head is left in entry 0 when the FIFO empties.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                r_F[i]  <= '0;
                r_rd[i] <= '0;
                r_tb[i] <= 1'b0;
            end
        end else begin
            if (w_push && !w_pop) begin
                if (r_count == 2'd0) begin
                    r_F[0]  <= in_F;
                    r_rd[0] <= in_rd;
                    r_tb[0] <= w_take;
                end else begin
                    r_F[1]  <= in_F;
                    r_rd[1] <= in_rd;
                    r_tb[1] <= w_take;
                end
                r_count <= r_count + 2'd1;
            end else if (w_pop && !w_push) begin
                if (r_count == 2'd2) begin
                    r_F[0]  <= r_F[1];
                    r_rd[0] <= r_rd[1];
                    r_tb[0] <= r_tb[1];
                end
                r_count <= r_count - 2'd1;
            end else if (w_push && w_pop) begin
                // Only reachable at count 1: the new beat replaces the departing head.
                r_F[0]  <= in_F;
                r_rd[0] <= in_rd;
                r_tb[0] <= w_take;
            end
        end
    end

    // Architectural flags, committed in program order at acceptance.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_flags <= '0;
        end else if (w_push && in_set_flags) begin
            r_flags <= in_status;
        end
    end

`ifdef TAKEN_COUNT_EN
    logic [31:0] r_taken_count;
    assign taken_count = r_taken_count;

    // Count popped heads that were taken branches; wraps naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_taken_count <= '0;
        end else if (w_pop && r_tb[0]) begin
            r_taken_count <= r_taken_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage (optionally with TAKEN_COUNT_EN).
module tb_alu_result_stage;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_F;
    logic [3:0]  in_status;
    logic        in_set_flags;
    logic        in_cond_br;
    logic [3:0]  in_cond;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_F;
    logic [4:0]  out_rd;
    logic        out_take_branch;
    logic [3:0]  flags;
`ifdef TAKEN_COUNT_EN
    logic [31:0] taken_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    alu_result_stage #(.DATA_W(64)) dut (
        .clock           (clock),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_F            (in_F),
        .in_status       (in_status),
        .in_set_flags    (in_set_flags),
        .in_cond_br      (in_cond_br),
        .in_cond         (in_cond),
        .in_rd           (in_rd),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_F           (out_F),
        .out_rd          (out_rd),
        .out_take_branch (out_take_branch),
`ifdef TAKEN_COUNT_EN
        .taken_count     (taken_count),
`endif
        .flags           (flags)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic beat(input logic v, input logic [63:0] f, input logic [4:0] rd,
                        input logic sf, input logic [3:0] st,
                        input logic cb, input logic [3:0] cc);
        in_valid     = v;
        in_F         = f;
        in_rd        = rd;
        in_set_flags = sf;
        in_status    = st;
        in_cond_br   = cb;
        in_cond      = cc;
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b0;
        beat(1'b0, 64'd0, 5'd0, 1'b0, 4'h0, 1'b0, 4'h0);

        // Reset state
        step();
        step();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_flags",     {60'd0, flags},     64'd0);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd0);
        chk("rst_out_F",     out_F,              64'd0);
        chk("rst_out_rd",    {59'd0, out_rd},    64'd0);
`ifdef TAKEN_COUNT_EN
        chk("rst_taken_count", {32'd0, taken_count}, 64'd0);
`endif
        reset = 1'b0;
        step();
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Flag set then branch: SUBS sets C,Z; B.EQ follows
        out_ready = 1'b1;
        beat(1'b1, 64'd0, 5'd3, 1'b1, 4'b0101, 1'b0, 4'h0);
        step();
        chk("subs_flags",   {60'd0, flags},     64'h5);
        chk("subs_valid",   {63'd0, out_valid}, 64'd1);
        chk("subs_rd",      {59'd0, out_rd},    64'd3);
        beat(1'b1, 64'hAA, 5'd4, 1'b0, 4'h0, 1'b1, 4'h0);
        step();
        chk("beq_F",        out_F,                    64'hAA);
        chk("beq_rd",       {59'd0, out_rd},          64'd4);
        chk("beq_taken",    {63'd0, out_take_branch}, 64'd1);
        beat(1'b0, 64'd0, 5'd0, 1'b0, 4'h0, 1'b0, 4'h0);
        step();
        chk("empty_valid",  {63'd0, out_valid},       64'd0);
        chk("empty_hold_F", out_F,                    64'hAA);
        chk("empty_hold_tb",{63'd0, out_take_branch}, 64'd1);

        // Same-beat ordering: condition sees flags from before this beat
        beat(1'b1, 64'd1, 5'd1, 1'b1, 4'b0000, 1'b0, 4'h0);
        step();
        chk("clr_flags", {60'd0, flags}, 64'h0);
        beat(1'b1, 64'd2, 5'd5, 1'b1, 4'b0001, 1'b1, 4'h0);
        step();
        chk("same_beat_F",     out_F,                    64'd2);
        chk("same_beat_taken", {63'd0, out_take_branch}, 64'd0);
        chk("same_beat_flags", {60'd0, flags},           64'h1);
        beat(1'b0, 64'd0, 5'd0, 1'b0, 4'h0, 1'b0, 4'h0);
        step();

        // Backpressure: three pushes into a two-entry FIFO
        out_ready = 1'b0;
        beat(1'b1, 64'd1, 5'd1, 1'b0, 4'h0, 1'b0, 4'h0);
        step();
        chk("bp_ready_1", {63'd0, in_ready}, 64'd1);
        beat(1'b1, 64'd2, 5'd2, 1'b0, 4'h0, 1'b0, 4'h0);
        step();
        chk("bp_ready_full", {63'd0, in_ready}, 64'd0);
        beat(1'b1, 64'd3, 5'd3, 1'b0, 4'h0, 1'b0, 4'h0);
        step();
        chk("bp_hold_ready", {63'd0, in_ready}, 64'd0);
        chk("bp_head_1",     out_F,             64'd1);
        out_ready = 1'b1;
        step();
        chk("bp_head_2",      out_F,             64'd2);
        chk("bp_reopen",      {63'd0, in_ready}, 64'd1);
        step();
        chk("bp_head_3",      out_F,             64'd3);
        chk("bp_head_3_rd",   {59'd0, out_rd},   64'd3);
        beat(1'b0, 64'd0, 5'd0, 1'b0, 4'h0, 1'b0, 4'h0);
        step();
        chk("bp_drained", {63'd0, out_valid}, 64'd0);
        chk("bp_flags_kept", {60'd0, flags}, 64'h1);

        // Signed conditions
        beat(1'b1, 64'd10, 5'd10, 1'b1, 4'b1000, 1'b0, 4'h0);
        step();
        chk("flags_1000", {60'd0, flags}, 64'h8);
        beat(1'b1, 64'd11, 5'd11, 1'b0, 4'h0, 1'b1, 4'hA);
        step();
        chk("ge_1000", {63'd0, out_take_branch}, 64'd0);
        beat(1'b1, 64'd12, 5'd12, 1'b0, 4'h0, 1'b1, 4'hB);
        step();
        chk("lt_1000", {63'd0, out_take_branch}, 64'd1);
        beat(1'b1, 64'd13, 5'd13, 1'b1, 4'b1010, 1'b0, 4'h0);
        step();
        beat(1'b1, 64'd14, 5'd14, 1'b0, 4'h0, 1'b1, 4'hA);
        step();
        chk("ge_1010", {63'd0, out_take_branch}, 64'd1);
        beat(1'b1, 64'd15, 5'd15, 1'b0, 4'h0, 1'b1, 4'hC);
        step();
        chk("gt_1010", {63'd0, out_take_branch}, 64'd1);
        beat(1'b1, 64'd16, 5'd16, 1'b1, 4'b1011, 1'b0, 4'h0);
        step();
        beat(1'b1, 64'd17, 5'd17, 1'b0, 4'h0, 1'b1, 4'hD);
        step();
        chk("le_1011", {63'd0, out_take_branch}, 64'd1);
        beat(1'b1, 64'd18, 5'd18, 1'b0, 4'h0, 1'b1, 4'hC);
        step();
        chk("gt_1011", {63'd0, out_take_branch}, 64'd0);
        beat(1'b1, 64'd19, 5'd19, 1'b0, 4'h0, 1'b0, 4'hE);
        step();
        chk("al_not_br", {63'd0, out_take_branch}, 64'd0);
        chk("al_not_br_F", out_F, 64'd19);
        beat(1'b0, 64'd0, 5'd0, 1'b0, 4'h0, 1'b0, 4'h0);
        step();
`ifdef TAKEN_COUNT_EN
        chk("taken_count", {32'd0, taken_count}, 64'd5);
`endif

        // Concurrent push/pop at count 1, then reset with a full FIFO
        out_ready = 1'b0;
        beat(1'b1, 64'd20, 5'd20, 1'b0, 4'h0, 1'b0, 4'h0);
        step();
        out_ready = 1'b1;
        beat(1'b1, 64'd21, 5'd21, 1'b0, 4'h0, 1'b0, 4'h0);
        step();
        chk("pp_valid", {63'd0, out_valid}, 64'd1);
        chk("pp_head",  out_F,              64'd21);
        chk("pp_ready", {63'd0, in_ready},  64'd1);
        out_ready = 1'b0;
        beat(1'b1, 64'd22, 5'd22, 1'b0, 4'h0, 1'b0, 4'h0);
        step();
        chk("pp_full", {63'd0, in_ready}, 64'd0);
        chk("pp_head_kept", out_F, 64'd21);
        reset     = 1'b1;
        out_ready = 1'b1;
        step();
        chk("midrst_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_flags", {60'd0, flags},     64'h0);
        chk("midrst_F",     out_F,              64'd0);
        chk("midrst_ready", {63'd0, in_ready},  64'd0);
`ifdef TAKEN_COUNT_EN
        chk("midrst_taken_count", {32'd0, taken_count}, 64'd0);
`endif
        reset = 1'b0;
        beat(1'b0, 64'd0, 5'd0, 1'b0, 4'h0, 1'b0, 4'h0);
        step();
        chk("after_rst_ready", {63'd0, in_ready},  64'd1);
        chk("after_rst_valid", {63'd0, out_valid}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered result stage directly downstream of the 64-bit LEGv8 ALU. Each cycle it can capture the ALU result `F` and the status nibble `{V,C,N,Z}` together with the destination register tag. It keeps the architectural NZCV flags register, evaluates B.cond conditions against it, and buffers results in a two-entry FIFO with valid/ready handshakes on both sides, so a stalled consumer never drops an ALU result.

## Interface
- `DATA_W`, default 64: width of the result datapath.
- `clock`, input, 1: rising-edge clock.
- `reset`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: upstream beat valid.
- `in_ready`, output, 1: stage can accept a beat. A beat is accepted when `in_valid & in_ready`.
- `in_F`, input, DATA_W: ALU result.
- `in_status`, input, 4: ALU status `{V,C,N,Z}`.
- `in_set_flags`, input, 1: beat is a flag-setting op (ADDS/SUBS/ANDS). `in_status` is committed to flags on accept.
- `in_cond_br`, input, 1: beat is a B.cond. Evaluate `in_cond`.
- `in_cond`, input, 4: LEGv8 condition code.
- `in_rd`, input, 5: destination register tag.
- `out_valid`, output, 1: FIFO head valid.
- `out_ready`, input, 1: downstream consumes the head when `out_valid & out_ready`.
- `out_F`, output, DATA_W: head result.
- `out_rd`, output, 5: head tag.
- `out_take_branch`, output, 1: head is a B.cond whose condition was true.
- `flags`, output, 4: current architectural `{V,C,N,Z}` register.

## Operation
- **FIFO storage:** two entries, each holding `{F, rd, take_branch}`. The count register takes values 0, 1 or 2.
  - `in_ready` = (count < 2) and not `reset`.
  - `out_valid` = (count != 0).
- **Push and pop:**
  - Push on accept.
  - Pop on `out_valid & out_ready`.
  - Push and pop in the same cycle leaves count unchanged, and order is preserved.
  - A push while count = 2 is impossible, because `in_ready` is 0.
  - A pop while empty is ignored.
- **Empty FIFO:** when empty, `out_F`, `out_rd` and `out_take_branch` hold the last popped values. After reset they are 0.
- **Flags register:**
  - On accept with `in_set_flags` = 1, `flags` ← `in_status` at the clock edge.
  - Otherwise `flags` holds.
  - Flags update at acceptance, not at pop, so they are in program order.
- **Condition evaluation:** uses the `flags` value registered before the current beat's update. This applies even when `in_set_flags` and `in_cond_br` are both 1 on the same beat.
- **Condition codes**, true when:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 HS: C
  - 3 LO: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C & !Z
  - 9 LS: !C | Z
  - A GE: N == V
  - B LT: N != V
  - C GT: !Z & (N == V)
  - D LE: Z | (N != V)
  - E AL: 1
  - F NV: 1
- **Branch result:** `take_branch` = `in_cond_br` & cond_true, stored in the entry.
- **Data path:** no arithmetic on `F`. It passes through at width DATA_W unchanged.

## Timing
- **Reset values:**
  - count = 0, `flags` = 4'b0000.
  - `out_valid` = 0, `out_F` = 0, `out_rd` = 0, `out_take_branch` = 0.
  - `in_ready` = 0 while `reset` is high, and 1 on the first cycle after reset deasserts.
- **Latency:** a beat accepted at edge k appears at the head with `out_valid` = 1 after edge k when the FIFO was empty. Otherwise it appears after all older entries pop.
- **Flags latency:** `flags` reflects a flag-setting beat one cycle after its accept edge.
- **`in_ready` timing:** `in_ready` depends only on registered count (and `reset`), with no combinational path from `out_ready`. A full FIFO reopens `in_ready` the cycle after a pop.
- **Reset mid-operation:** all entries are discarded and flags are cleared at the reset edge, regardless of concurrent valid/ready.

## Configuration
- **`TAKEN_COUNT_EN` defined:**
  - Adds output `taken_count` [31:0], reset to 0.
  - Increments by 1 on each pop whose `out_take_branch` = 1, wrapping 32'hFFFFFFFF → 0.
- **`TAKEN_COUNT_EN` undefined:** the port and counter do not exist, and behaviour is otherwise identical.

## Test plan
- **Reset state:** hold `reset` for 2 cycles → `out_valid` = 0, `flags` = 0000, `in_ready` = 0. The cycle after release → `in_ready` = 1.
- **Flag set then branch:**
  - Push SUBS with F = 0, `in_status` = 4'b0101 (C,Z), `in_set_flags` = 1.
  - Then push B.EQ (`in_cond` = 0).
  - Required: `flags` = 0101, and the second head has `out_take_branch` = 1.
- **Same-beat ordering:**
  - Start with `flags` = 0000.
  - Push one beat with `in_set_flags` = 1, `in_status` = 0001, `in_cond_br` = 1, `in_cond` = 0 (EQ).
  - Required: `out_take_branch` = 0, then `flags` = 0001.
- **Backpressure:**
  - With `out_ready` = 0, push F = 1, 2, 3 on consecutive cycles.
  - Required: `in_ready` = 0 after two accepts, and the third beat is held.
  - Then raise `out_ready` → outputs 1, 2, 3 in order, with no loss.
- **Signed conditions:**
  - `flags` = 1000 (V=1, N=0) → GE false, LT true.
  - `flags` = 1010 → GE true, GT true.
  - `flags` = 1011 → LE true.
- **Concurrent push/pop and mid-operation reset:**
  - At count = 1, push and pop in the same cycle → count stays 1 and the new value is at the head next cycle.
  - Assert `reset` with count = 2 → `out_valid` = 0 next cycle.
  - With `TAKEN_COUNT_EN`, `taken_count` = 0 after reset.
